// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types, widths and speed defaults for the dino runner
//
// Purpose : game-state encoding, bus widths and the default speed constants
//           used by the scroll scheduler and by any speed consumer.
// Contents: PERIOD_W, LEVEL_W, DEF_* speed defaults, state_t,
//           next_period() guarded period step, half_period() boost helper.
package dino_pkg;

   localparam int PERIOD_W = 21;
   localparam int LEVEL_W  = 5;

   localparam logic [PERIOD_W-1:0] DEF_INIT_PERIOD  = 21'd450000;
   localparam logic [PERIOD_W-1:0] DEF_STEP         = 21'd20000;
   localparam logic [PERIOD_W-1:0] DEF_MIN_PERIOD   = 21'd130000;
   localparam logic [31:0]         DEF_LEVEL_CYCLES = 32'd500000000;
   localparam logic [LEVEL_W-1:0]  DEF_MAX_LEVEL    = 5'd16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      OVER  = 2'b11
   } state_t;

   // Period after one level-up. The compare runs one bit wider so that
   // step + floor cannot wrap, and the subtraction only happens when the
   // result is known to stay at or above the floor.
   function automatic logic [PERIOD_W-1:0] next_period(
      input logic [PERIOD_W-1:0] cur,
      input logic [PERIOD_W-1:0] step,
      input logic [PERIOD_W-1:0] floor_p
   );
      logic [PERIOD_W:0] w_limit;
      w_limit = {1'b0, step} + {1'b0, floor_p};
      if ({1'b0, cur} < w_limit)
         return floor_p;
      else
         return cur - step;
   endfunction

   // Half period for boost, never below one clock.
   function automatic logic [PERIOD_W-1:0] half_period(
      input logic [PERIOD_W-1:0] cur
   );
      logic [PERIOD_W-1:0] w_half;
      w_half = cur >> 1;
      if (w_half == '0)
         return {{(PERIOD_W-1){1'b0}}, 1'b1};
      else
         return w_half;
   endfunction

endpackage

// File: rtl/scroll_scheduler_if.sv
// rtl/scroll_scheduler_if.sv - control/status bundle between game logic and the scroll scheduler
//
// Purpose : groups the scheduler's game-control inputs and speed/status outputs.
// Signals : start, pause_tgl, collide, boost  (game logic -> scheduler)
//           tick, period[20:0], level[4:0], state[1:0] (scheduler -> consumers)
// Modports: master = game logic / bench side, slave = scroll_scheduler side.
interface scroll_scheduler_if;
   import dino_pkg::*;

   logic                start;
   logic                pause_tgl;
   logic                collide;
   logic                boost;
   logic                tick;
   logic [PERIOD_W-1:0] period;
   logic [LEVEL_W-1:0]  level;
   logic [1:0]          state;

   modport master (
      output start, pause_tgl, collide, boost,
      input  tick, period, level, state
   );

   modport slave (
      input  start, pause_tgl, collide, boost,
      output tick, period, level, state
   );

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - programmable scroll tick divider
//
// Purpose : counts enabled clocks and emits a registered one-cycle tick each
//           time the count reaches the requested period.
// Ports   : clk          in   system clock
//           rst          in   synchronous reset, active-high
//           i_en         in   count this cycle
//           i_clr        in   restart the count (also drops tick)
//           i_period_in  in   effective period in clocks
//           o_tick       out  one-cycle strobe, registered
module tick_divider
   import dino_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic                i_clr,
   input  logic [PERIOD_W-1:0] i_period_in,
   output logic                o_tick
);

   logic [PERIOD_W-1:0] r_tick_cnt;
   logic                r_tick;
   logic                w_due;

   // "count + 1 >= period" is "count >= period - 1" without underflow when
   // period is 0. Using >= means a period that shrinks below the running
   // count fires on the next enabled cycle instead of wrapping past it.
   assign w_due = ({1'b0, r_tick_cnt} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, i_period_in};

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (i_en) begin
         if (w_due) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
         end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            r_tick     <= 1'b0;
         end
      end else begin
         // Frozen: count holds, no strobe.
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/scroll_scheduler.sv
// rtl/scroll_scheduler.sv - dino runner game-speed controller
//
// Purpose : run/pause/over sequencing, periodic difficulty ramp and the
//           scroll tick for the obstacle/ground scrollers.
// Ports   : clk   in   system clock
//           rstn  in   synchronous reset, active-high (1 = reset)
//           bus   slave modport of scroll_scheduler_if:
//                 start, pause_tgl, collide, boost in; tick, period, level, state out
// Options : SCROLL_BOOST_EN - when defined, boost halves the effective tick
//           period (minimum 1) without touching period, level or level timer.
module scroll_scheduler
   import dino_pkg::*;
#(
   parameter logic [PERIOD_W-1:0] INIT_PERIOD  = DEF_INIT_PERIOD,
   parameter logic [PERIOD_W-1:0] STEP         = DEF_STEP,
   parameter logic [PERIOD_W-1:0] MIN_PERIOD   = DEF_MIN_PERIOD,
   parameter logic [31:0]         LEVEL_CYCLES = DEF_LEVEL_CYCLES,
   parameter logic [LEVEL_W-1:0]  MAX_LEVEL    = DEF_MAX_LEVEL
)(
   input  logic             clk,
   input  logic             rstn,
   scroll_scheduler_if.slave bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_run_cnt;
   logic                w_restart;
   logic [PERIOD_W-1:0] r_period;
   logic [LEVEL_W-1:0]  r_level;
   logic [31:0]         r_lvl_cnt;
   logic [PERIOD_W-1:0] w_eff_period;
   logic                w_tick;

   // ---------------------------------------------------------------
   // Game FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rstn)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // In RUN, collide beats pause_tgl and both beat counting: on those
   // cycles neither timer advances, which also drops a tick due that cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_run_cnt   = 1'b0;
      w_restart   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
               w_restart   = 1'b1;
            end
         end
         RUN: begin
            if (bus.collide)
               w_state_nxt = OVER;
            else if (bus.pause_tgl)
               w_state_nxt = PAUSE;
            else
               w_run_cnt = 1'b1;
         end
         PAUSE: begin
            if (bus.pause_tgl)
               w_state_nxt = RUN;
         end
         OVER: begin
            if (bus.start) begin
               w_state_nxt = RUN;
               w_restart   = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Level timer and period ramp
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rstn || w_restart) begin
         r_period  <= INIT_PERIOD;
         r_level   <= '0;
         r_lvl_cnt <= '0;
      end else if (w_run_cnt) begin
         if (r_lvl_cnt == LEVEL_CYCLES - 32'd1) begin
            r_lvl_cnt <= '0;
            // Once saturated, level-ups stop changing the period as well.
            if (r_level < MAX_LEVEL) begin
               r_level  <= r_level + LEVEL_W'(1);
               r_period <= next_period(r_period, STEP, MIN_PERIOD);
            end
         end else begin
            r_lvl_cnt <= r_lvl_cnt + 32'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Tick generation
   // ---------------------------------------------------------------
`ifdef SCROLL_BOOST_EN
   assign w_eff_period = bus.boost ? half_period(r_period) : r_period;
`else
   assign w_eff_period = r_period;
`endif

   tick_divider u_tick_divider (
      .clk         (clk),
      .rst         (rstn),
      .i_en        (w_run_cnt),
      .i_clr       (w_restart),
      .i_period_in (w_eff_period),
      .o_tick      (w_tick)
   );

   assign bus.tick   = w_tick;
   assign bus.period = r_period;
   assign bus.level  = r_level;
   assign bus.state  = r_state;

endmodule
